ifetch_ifid: RTL and testbench
==============================

// Module: ifetch_ifid
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage core. Owns the PC, drives
//  the instruction-memory request/ready handshake and presents {pc, pc+4, instruction, valid} to ID.
//  Consumes PC_IFWrite from the hazard unit (load-use/Mfc0 stall), branch/jump redirects from ID,
//  and exception/eret redirects from CP0. No branch delay slot: a taken redirect squashes the younger fetch.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  EXC_VECTOR  32'h0000_F000  exception entry address
// PORTS
//  clock            in   1   system clock, all state updates on rising edge
//  reset            in   1   asynchronous, active-high
//  PC_IFWrite       in   1   1 = advance; 0 = hold PC and IF/ID (hazard stall)
//  branch_taken     in   1   ID-resolved taken branch/jump, honoured only when PC_IFWrite=1
//  branch_target    in   32  redirect address for branch_taken
//  exc_req          in   1   CP0 exception, honoured regardless of PC_IFWrite
//  eret             in   1   return from exception, honoured regardless of PC_IFWrite
//  epc              in   32  redirect address for eret
//  imem_req         out  1   fetch request valid
//  imem_addr        out  32  fetch address (word aligned), stable while imem_req=1 and imem_ready=0
//  imem_rdata       in   32  instruction, valid when imem_ready=1
//  imem_ready       in   1   one-cycle data-return strobe for the outstanding request
//  if_id_pc         out  32  PC of instruction in IF/ID
//  if_id_pc_plus4   out  32  if_id_pc + 4 (mod 2^32)
//  if_id_instruction out 32  instruction in IF/ID (32'h0 when bubble)
//  if_id_valid      out  1   1 = IF/ID holds a real instruction
//  fetch_busy       out  1   1 while state != FETCH (debug/perf)
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instruction=0, if_id_pc=0,
//    if_id_pc_plus4=0, pending target=0, hold buffer cleared. Release takes effect next edge.
//  - Redirect priority: exc_req > eret > (branch_taken & PC_IFWrite). Target = EXC_VECTOR / epc /
//    branch_target. Any redirect clears IF/ID to bubble (valid=0, instruction=0) at that edge.
//  - States:
//    FETCH: imem_req=1, imem_addr=pc. On imem_ready & PC_IFWrite & no redirect: IF/ID <= {pc, pc+4,
//      rdata, 1}; pc <= pc+4; stay. Ready with PC_IFWrite=0: rdata -> hold buffer, go HOLD, IF/ID
//      unchanged. No ready & PC_IFWrite=1: IF/ID <= bubble. No ready & PC_IFWrite=0: IF/ID held.
//      Redirect with imem_ready=1 same cycle: drop rdata, pc <= target, stay FETCH.
//      Redirect with imem_ready=0: latch target, go DISCARD.
//    HOLD: imem_req=0. PC_IFWrite=1 & no redirect: IF/ID <= buffered instr, pc <= pc+4, go FETCH.
//      Redirect: drop buffer, pc <= target, go FETCH. PC_IFWrite=0: hold everything.
//    DISCARD: imem_req=1, imem_addr=old pc (request must complete). On imem_ready: drop data,
//      pc <= pending target, go FETCH. A newer redirect while in DISCARD overwrites pending target
//      (same priority). IF/ID is bubble while in DISCARD unless PC_IFWrite=0 (then held).
//  - Latency: instruction enters IF/ID on the edge where imem_ready=1 (FETCH) or PC_IFWrite rises (HOLD).
//    Zero-wait memory (ready every cycle) gives one instruction per cycle, redirect penalty 1 bubble.
//  - PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Targets used as given; bits[1:0] ignored
//    on imem_addr (forced 00).
//  - Stall never drops or duplicates an instruction; the hold buffer is the only skid storage (depth 1).
//  - Reset asserted mid-request: state/outputs return to reset values immediately; bench memory must
//    discard its in-flight response.
// TESTING
//  1 Reset, zero-wait imem returning addr as data -> IF/ID pc 0,4,8,... one per cycle, valid=1 from cycle 2.
//  2 PC_IFWrite=0 for 3 cycles with pc=0x10 and data ready -> state HOLD, IF/ID held, then 0x10 instr
//    enters on release, next fetch addr 0x14; no duplicate/missing instruction.
//  3 branch_taken=1, target 0x100, at pc=0x20 -> one bubble (valid=0), next valid pc=0x100;
//    same with PC_IFWrite=0 -> ignored, pc unchanged.
//  4 imem_ready delayed 3 cycles, exc_req in wait cycle 1 -> imem_addr stays 0x40 until ready,
//    data dropped, next fetch addr 0x0000_F000; IF/ID bubbles throughout.
//  5 exc_req and eret and branch_taken same cycle -> pc=EXC_VECTOR; eret alone, epc=0x200 -> pc=0x200.
//  6 pc=0xFFFF_FFFC -> if_id_pc_plus4=0, next fetch 0x0; async reset mid-wait -> outputs zero
//    before next edge, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/ifetch_ifid.sv
// ifetch_ifid
//   Instruction-fetch stage and IF/ID pipeline register of the 5-stage core.
//   Owns the PC and drives the instruction-memory request. It presents
//   {pc, pc+4, instruction, valid} to the decode stage. The hazard unit can
//   stall it, ID can redirect it (branch/jump) and CP0 can redirect it
//   (exception/eret). There is no branch delay slot: a taken redirect squashes
//   the younger fetch.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   PC_IFWrite            1 = advance, 0 = hold PC and IF/ID (hazard stall)
//   branch_taken/target   ID redirect, honoured only while PC_IFWrite=1
//   exc_req               CP0 exception -> EXC_VECTOR, honoured regardless of stall
//   eret/epc              return from exception -> epc, honoured regardless of stall
//   imem_req/addr         fetch request and word-aligned fetch address
//   imem_rdata/ready      returned instruction and its one-cycle strobe
//   if_id_*               IF/ID register contents
//   fetch_busy            1 while not in FETCH
//   fetch_state           raw FSM state (0 FETCH, 1 HOLD, 2 DISCARD) for debug
//
// Memory handshake: while imem_req=1 the request is outstanding and imem_addr
// stays stable. The memory answers with exactly one imem_ready pulse, and
// imem_rdata is valid in that cycle. A request cannot be cancelled, so it
// always completes: a redirect that arrives before the answer is parked in
// DISCARD until the stale data returns.

module ifetch_ifid #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_F000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PC_IFWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        fetch_busy,
    output logic [1:0]  fetch_state
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend, pend_nxt;      // redirect target parked during DISCARD
    logic [31:0] hold_buf, hold_nxt;  // single skid entry for a stalled fetch
    logic [31:0] ifid_pc_nxt, ifid_pc4_nxt, ifid_instr_nxt;
    logic        ifid_valid_nxt;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Branches only count when the pipeline advances; CP0 redirects always win.
    assign redirect = exc_req | eret | (branch_taken & PC_IFWrite);
    assign target   = exc_req ? EXC_VECTOR : (eret ? epc : branch_target);
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            pend              <= 32'h0;
            hold_buf          <= 32'h0;
            if_id_pc          <= 32'h0;
            if_id_pc_plus4    <= 32'h0;
            if_id_instruction <= 32'h0;
            if_id_valid       <= 1'b0;
        end else begin
            state             <= state_nxt;
            pc                <= pc_nxt;
            pend              <= pend_nxt;
            hold_buf          <= hold_nxt;
            if_id_pc          <= ifid_pc_nxt;
            if_id_pc_plus4    <= ifid_pc4_nxt;
            if_id_instruction <= ifid_instr_nxt;
            if_id_valid       <= ifid_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_nxt       = pend;
        hold_nxt       = hold_buf;
        ifid_pc_nxt    = if_id_pc;
        ifid_pc4_nxt   = if_id_pc_plus4;
        ifid_instr_nxt = if_id_instruction;
        ifid_valid_nxt = if_id_valid;

        case (state)
            FETCH: begin
                if (redirect) begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = 32'h0;
                    if (imem_ready) begin
                        pc_nxt = target;
                    end else begin
                        pend_nxt  = target;
                        state_nxt = DISCARD;
                    end
                end else if (imem_ready) begin
                    if (PC_IFWrite) begin
                        ifid_pc_nxt    = pc;
                        ifid_pc4_nxt   = pc_plus4;
                        ifid_instr_nxt = imem_rdata;
                        ifid_valid_nxt = 1'b1;
                        pc_nxt         = pc_plus4;
                    end else begin
                        // Stalled while the data arrives: park it so it is not lost.
                        hold_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end else if (PC_IFWrite) begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = 32'h0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = 32'h0;
                    hold_nxt       = 32'h0;
                    pc_nxt         = target;
                    state_nxt      = FETCH;
                end else if (PC_IFWrite) begin
                    ifid_pc_nxt    = pc;
                    ifid_pc4_nxt   = pc_plus4;
                    ifid_instr_nxt = hold_buf;
                    ifid_valid_nxt = 1'b1;
                    hold_nxt       = 32'h0;
                    pc_nxt         = pc_plus4;
                    state_nxt      = FETCH;
                end
            end

            DISCARD: begin
                if (redirect) begin
                    pend_nxt = target;
                end
                if (redirect || PC_IFWrite) begin
                    ifid_valid_nxt = 1'b0;
                    ifid_instr_nxt = 32'h0;
                end
                if (imem_ready) begin
                    // A redirect in the very cycle the stale data lands still counts.
                    pc_nxt    = redirect ? target : pend;
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign imem_req    = (state != HOLD);
    assign imem_addr   = {pc[31:2], 2'b00};
    assign fetch_busy  = (state != FETCH);
    assign fetch_state = state;

endmodule

// File: tb/tb_ifetch_ifid.sv
module tb_ifetch_ifid;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        PC_IFWrite, branch_taken, exc_req, eret;
  logic [31:0] branch_target, epc;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instruction;
  logic        if_id_valid, fetch_busy;
  logic [1:0]  fetch_state;

  always #5 clock = ~clock;

  ifetch_ifid dut (
    .clock(clock), .reset(reset), .PC_IFWrite(PC_IFWrite),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .exc_req(exc_req), .eret(eret), .epc(epc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
    .fetch_busy(fetch_busy), .fetch_state(fetch_state)
  );

  // ---------------- memory model ----------------
  // Auto mode: zero-wait memory answering every request with its own address.
  // Manual mode: the stimulus drives ready/data directly.
  logic        mem_auto;
  logic        man_ready;
  logic [31:0] man_rdata;

  always_comb begin
    imem_ready = mem_auto ? imem_req : man_ready;
    imem_rdata = mem_auto ? imem_addr : man_rdata;
  end

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        adv = 1'b0;

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, pc + 32'd4, instr});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ID consumes IF/ID whenever the stage advanced; a valid entry after an
  // advancing edge is a newly delivered instruction.
  always @(posedge clock) adv = PC_IFWrite;

  always @(negedge clock) begin
    logic [95:0] got, want;
    if (!reset && adv && if_id_valid) begin
      got = {if_id_pc, if_id_pc_plus4, if_id_instruction};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ifid_unexpected act=%h exp=none @%0t", got, $time);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL ifid_entry act=%h exp=%h @%0t", got, want, $time);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; PC_IFWrite = 1'b1; branch_taken = 1'b0; exc_req = 1'b0; eret = 1'b0;
    branch_target = 32'h0; epc = 32'h0;
    mem_auto = 1'b1; man_ready = 1'b0; man_rdata = 32'h0;
    tick(); tick();

    // Reset state
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instruction, 32'h0);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_busy", {31'h0, fetch_busy}, 32'h0);

    // 1: zero-wait streaming, then 2: stall at pc 0x10
    for (int i = 0; i < 8; i++) push(32'(i * 4), 32'(i * 4));
    reset = 1'b0;                                   // N0
    tick();                                         // N1
    chk("t1_addr_next", imem_addr, 32'h4);
    tick(); tick(); tick();                         // N4, pc=0x10
    PC_IFWrite = 1'b0;
    tick();                                         // N5
    chk("t2_state_hold", {30'h0, fetch_state}, 32'h1);
    chk("t2_req_low", {31'h0, imem_req}, 32'h0);
    chk("t2_ifid_held", if_id_pc, 32'hC);
    chk("t2_valid_held", {31'h0, if_id_valid}, 32'h1);
    tick(); tick();                                 // N7
    chk("t2_ifid_still", if_id_pc, 32'hC);
    PC_IFWrite = 1'b1;
    tick();                                         // N8
    chk("t2_addr_after", imem_addr, 32'h14);
    chk("t2_busy_after", {31'h0, fetch_busy}, 32'h0);

    // 3: taken branch at pc 0x20, then a branch during stall is ignored
    push(32'h100, 32'h100); push(32'h104, 32'h104); push(32'h108, 32'h108);
    tick(); tick(); tick();                         // N11, pc=0x20
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();                                         // N12
    chk("t3_bubble", {31'h0, if_id_valid}, 32'h0);
    chk("t3_bubble_instr", if_id_instruction, 32'h0);
    chk("t3_addr", imem_addr, 32'h100);
    branch_taken = 1'b0;
    tick(); tick();                                 // N14, pc=0x108
    branch_taken = 1'b1; branch_target = 32'h300; PC_IFWrite = 1'b0;
    tick();                                         // N15
    chk("t3_stall_hold", {31'h0, fetch_busy}, 32'h1);
    chk("t3_stall_ifid", if_id_pc, 32'h104);
    branch_taken = 1'b0; PC_IFWrite = 1'b1;
    tick();                                         // N16
    chk("t3_ignored_addr", imem_addr, 32'h10C);

    // 4: go to 0x40, slow memory, exception in wait cycle 1
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();                                         // N17
    branch_taken = 1'b0; mem_auto = 1'b0; man_ready = 1'b0;
    chk("t4_addr_start", imem_addr, 32'h40);
    exc_req = 1'b1;
    tick();                                         // N18
    exc_req = 1'b0;
    chk("t4_addr_w1", imem_addr, 32'h40);
    chk("t4_state_discard", {30'h0, fetch_state}, 32'h2);
    chk("t4_bubble_w1", {31'h0, if_id_valid}, 32'h0);
    tick();                                         // N19
    chk("t4_addr_w2", imem_addr, 32'h40);
    chk("t4_bubble_w2", {31'h0, if_id_valid}, 32'h0);
    tick();                                         // N20
    chk("t4_addr_w3", imem_addr, 32'h40);
    man_ready = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();                                         // N21
    man_ready = 1'b0; mem_auto = 1'b1;
    chk("t4_addr_vec", imem_addr, 32'h0000_F000);
    chk("t4_bubble_end", {31'h0, if_id_valid}, 32'h0);
    chk("t4_busy_end", {31'h0, fetch_busy}, 32'h0);
    push(32'h0000_F000, 32'h0000_F000);

    // 5: priority exc > eret > branch, then eret alone
    tick();                                         // N22
    exc_req = 1'b1; eret = 1'b1; branch_taken = 1'b1;
    epc = 32'h200; branch_target = 32'h300;
    tick();                                         // N23
    chk("t5_prio_addr", imem_addr, 32'h0000_F000);
    chk("t5_prio_bubble", {31'h0, if_id_valid}, 32'h0);
    exc_req = 1'b0; branch_taken = 1'b0;
    tick();                                         // N24
    chk("t5_eret_addr", imem_addr, 32'h200);
    eret = 1'b0;
    push(32'h200, 32'h200);

    // 6: wrap at the top of the address space
    tick();                                         // N25
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC, 32'hFFFF_FFFC); push(32'h0, 32'h0); push(32'h4, 32'h4);
    tick();                                         // N26
    branch_taken = 1'b0;
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();                                         // N27
    chk("t6_pc4_wrap", if_id_pc_plus4, 32'h0);
    chk("t6_addr_wrap", imem_addr, 32'h0);
    tick(); tick();                                 // N29, pc=8
    mem_auto = 1'b0; man_ready = 1'b0; PC_IFWrite = 1'b0;
    tick();                                         // N30
    chk("t6_held_valid", {31'h0, if_id_valid}, 32'h1);
    chk("t6_held_pc", if_id_pc, 32'h4);
    chk("t6_wait_addr", imem_addr, 32'h8);

    // async reset while the request is outstanding; its response is dropped
    #2 reset = 1'b1;
    #1;
    chk("t6_ar_valid", {31'h0, if_id_valid}, 32'h0);
    chk("t6_ar_pc", if_id_pc, 32'h0);
    chk("t6_ar_pc4", if_id_pc_plus4, 32'h0);
    chk("t6_ar_addr", imem_addr, 32'h0);
    tick();                                         // N31
    reset = 1'b0; PC_IFWrite = 1'b1; mem_auto = 1'b1;
    push(32'h0, 32'h0); push(32'h4, 32'h4); push(32'h8, 32'h8);
    tick(); tick(); tick();                         // N34
    PC_IFWrite = 1'b0;
    tick();                                         // N35
    #1;
    chk("drain_q_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
